// File: rtl/q6_fsm_state_reg.sv
// ---------------------------------------------------------------------------
// q6_fsm_state_reg
// State-register stage of the six-state w-driven FSM.
// It holds the state code y[3:1] and applies the full next-state function.
// It also decodes the Moore output z and keeps bring-up counters.
//
// Ports
//   clk        in   1      rising-edge clock
//   resetn     in   1      synchronous active-low reset
//   en         in   1      advance enable (0 = hold)
//   w          in   1      FSM input, sampled when en=1
//   ld         in   1      load ld_state into y (overrides en)
//   ld_state   in   3      state code to load, bits [3:1]
//   y          out  3      current state, bits [3:1]
//   y_nxt      out  3      combinational next state for current y/w
//   z          out  1      Moore output, high in E or F
//   err        out  1      sticky flag: an illegal code was loaded
//   e_run      out  CNT_W  consecutive E->E self-loops (saturating)
//   trans_cnt  out  CNT_W  state changes taken via en (wrapping)
// ---------------------------------------------------------------------------
module q6_fsm_state_reg #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             w,
    input  logic             ld,
    input  logic [3:1]       ld_state,
    output logic [3:1]       y,
    output logic [3:1]       y_nxt,
    output logic             z,
    output logic             err,
    output logic [CNT_W-1:0] e_run,
    output logic [CNT_W-1:0] trans_cnt
);

    localparam logic [3:1] S_A = 3'b000;
    localparam logic [3:1] S_B = 3'b001;
    localparam logic [3:1] S_C = 3'b010;
    localparam logic [3:1] S_D = 3'b011;
    localparam logic [3:1] S_E = 3'b100;
    localparam logic [3:1] S_F = 3'b101;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:1]       r_y;
    logic             r_err;
    logic [CNT_W-1:0] r_e_run;
    logic [CNT_W-1:0] r_trans_cnt;

    logic [3:1]       w_y_nxt;
    logic [3:1]       w_y_d;
    logic             w_err_d;
    logic [CNT_W-1:0] w_e_run_d;
    logic [CNT_W-1:0] w_trans_cnt_d;
    logic             w_ld_legal;
    logic             w_z;

    // State register: holds y, sticky err and the observation counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_y         <= S_A;
            r_err       <= 1'b0;
            r_e_run     <= '0;
            r_trans_cnt <= '0;
        end else begin
            r_y         <= w_y_d;
            r_err       <= w_err_d;
            r_e_run     <= w_e_run_d;
            r_trans_cnt <= w_trans_cnt_d;
        end
    end

    // Next-state logic: transition table plus ld/en priority and counter updates.
    always_comb begin
        case (r_y)
            S_A:     w_y_nxt = w ? S_A : S_B;
            S_B:     w_y_nxt = w ? S_D : S_C;
            S_C:     w_y_nxt = w ? S_D : S_E;
            S_D:     w_y_nxt = w ? S_A : S_F;
            S_E:     w_y_nxt = w ? S_D : S_E;
            S_F:     w_y_nxt = w ? S_D : S_C;
            default: w_y_nxt = S_A;   // illegal codes recover to A
        endcase

        // 110 and 111 are the only illegal codes.
        w_ld_legal    = (ld_state[3:2] != 2'b11);

        w_y_d         = r_y;
        w_err_d       = r_err;
        w_e_run_d     = r_e_run;
        w_trans_cnt_d = r_trans_cnt;

        if (ld) begin
            if (w_ld_legal) begin
                w_y_d   = ld_state;
                w_err_d = r_err;
            end else begin
                w_y_d   = S_A;
                w_err_d = 1'b1;
            end
            w_e_run_d = '0;
        end else if (en) begin
            w_y_d = w_y_nxt;
            // A self-loop is not a state change, so it does not count.
            if (w_y_nxt != r_y) begin
                w_trans_cnt_d = r_trans_cnt + CNT_ONE;
            end else begin
                w_trans_cnt_d = r_trans_cnt;
            end
            if ((r_y == S_E) && (w_y_nxt == S_E)) begin
                if (r_e_run != CNT_MAX) begin
                    w_e_run_d = r_e_run + CNT_ONE;
                end else begin
                    w_e_run_d = CNT_MAX;
                end
            end else begin
                w_e_run_d = '0;
            end
        end else begin
            w_y_d = r_y;
        end
    end

    // Output decode: z is a pure decode of the registered state.
    always_comb begin
        case (r_y)
            S_E:     w_z = 1'b1;
            S_F:     w_z = 1'b1;
            default: w_z = 1'b0;
        endcase
    end

    assign y         = r_y;
    assign y_nxt     = w_y_nxt;
    assign z         = w_z;
    assign err       = r_err;
    assign e_run     = r_e_run;
    assign trans_cnt = r_trans_cnt;

endmodule

// File: tb/tb_q6_fsm_state_reg.sv
module tb_q6_fsm_state_reg;

    logic       clk;
    logic       resetn;
    logic       en;
    logic       w;
    logic       ld;
    logic [3:1] ld_state;
    logic [3:1] y;
    logic [3:1] y_nxt;
    logic       z;
    logic       err;
    logic [7:0] e_run;
    logic [7:0] trans_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] y;
        logic       z;
        logic       err;
        logic [7:0] erun;
        logic [7:0] tc;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [2:0] m_y;
    logic       m_err;
    logic [7:0] m_erun;
    logic [7:0] m_tc;

    q6_fsm_state_reg #(.CNT_W(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .w         (w),
        .ld        (ld),
        .ld_state  (ld_state),
        .y         (y),
        .y_nxt     (y_nxt),
        .z         (z),
        .err       (err),
        .e_run     (e_run),
        .trans_cnt (trans_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transition table: A->B/A B->C/D C->E/D D->F/A E->E/D F->C/D
    function automatic logic [2:0] tbl_nxt(input logic [2:0] s, input logic wi);
        logic [2:0] r;
        case (s)
            3'd0:    r = wi ? 3'd0 : 3'd1;
            3'd1:    r = wi ? 3'd3 : 3'd2;
            3'd2:    r = wi ? 3'd3 : 3'd4;
            3'd3:    r = wi ? 3'd0 : 3'd5;
            3'd4:    r = wi ? 3'd3 : 3'd4;
            3'd5:    r = wi ? 3'd3 : 3'd2;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one clock of stimulus, push the model's expectation, then pop and compare.
    task automatic step(input logic rn, input logic ldi, input logic [2:0] lds,
                        input logic eni, input logic wi);
        exp_t e;
        logic [2:0] n;
        resetn   = rn;
        ld       = ldi;
        ld_state = lds;
        en       = eni;
        w        = wi;
        if (!rn) begin
            m_y = 3'd0; m_err = 1'b0; m_erun = 8'd0; m_tc = 8'd0;
        end else if (ldi) begin
            if (lds[2:1] != 2'b11) m_y = lds;
            else begin m_y = 3'd0; m_err = 1'b1; end
            m_erun = 8'd0;
        end else if (eni) begin
            n = tbl_nxt(m_y, wi);
            if (n != m_y) m_tc = m_tc + 8'd1;
            if (m_y == 3'd4 && n == 3'd4) m_erun = (m_erun == 8'hFF) ? 8'hFF : m_erun + 8'd1;
            else m_erun = 8'd0;
            m_y = n;
        end
        e.y = m_y; e.z = (m_y == 3'd4) || (m_y == 3'd5); e.err = m_err;
        e.erun = m_erun; e.tc = m_tc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_y",    {29'd0, y},     {29'd0, e.y});
        chk("sb_z",    {31'd0, z},     {31'd0, e.z});
        chk("sb_err",  {31'd0, err},   {31'd0, e.err});
        chk("sb_erun", {24'd0, e_run}, {24'd0, e.erun});
        chk("sb_tc",   {24'd0, trans_cnt}, {24'd0, e.tc});
    endtask

    initial begin
        logic [11:0] y2_tab;
        logic [2:0]  wseq;
        y2_tab = 12'b1110_0010_1100; // index {y,w}: bit = expected Y2
        m_y = 3'd0; m_err = 1'b0; m_erun = 8'd0; m_tc = 8'd0;
        resetn = 1'b0; en = 1'b0; w = 1'b0; ld = 1'b0; ld_state = 3'd0;

        // 1. reset
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("rst_y", {29'd0, y}, 32'd0);
        chk("rst_z", {31'd0, z}, 32'd0);
        resetn = 1'b1; w = 1'b0; #1;
        chk("rst_ynxt_w0", {29'd0, y_nxt}, 32'd1);
        w = 1'b1; #1;
        chk("rst_ynxt_w1", {29'd0, y_nxt}, 32'd0);

        // 2. A, w=0 x4 -> B C E E
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("seq2_y1", {29'd0, y}, 32'd1);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("seq2_y2", {29'd0, y}, 32'd2);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("seq2_z3", {31'd0, z}, 32'd1);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("seq2_y4", {29'd0, y}, 32'd4);
        chk("seq2_erun", {24'd0, e_run}, 32'd1);
        chk("seq2_tc", {24'd0, trans_cnt}, 32'd3);

        // 3. A, w=0,1,0,0 -> B D F C
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        wseq = 3'b010;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, 1'b1, wseq[i]);
        chk("seq3_yF", {29'd0, y}, 32'd5);
        chk("seq3_zF", {31'd0, z}, 32'd1);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("seq3_yC", {29'd0, y}, 32'd2);
        chk("seq3_zC", {31'd0, z}, 32'd0);
        chk("seq3_tc", {24'd0, trans_cnt}, 32'd4);

        // Y2 table over all 12 legal {y,w}
        for (int s = 0; s < 6; s++) begin
            step(1'b1, 1'b1, 3'(s), 1'b0, 1'b0);
            ld = 1'b0;
            for (int wi = 0; wi < 2; wi++) begin
                w = 1'(wi); #1;
                chk("y2_tab", {31'd0, y_nxt[2]}, {31'd0, y2_tab[s*2+wi]});
            end
        end

        // 4. hold with en=0 from F while w toggles
        step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd0, 1'b0, 1'(i));
        chk("hold_y", {29'd0, y}, 32'd5);
        chk("hold_z", {31'd0, z}, 32'd1);
        step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
        chk("selfloop_y", {29'd0, y}, 32'd0);

        // 5. illegal load, legal load, reset clears err
        step(1'b1, 1'b1, 3'b110, 1'b0, 1'b0);
        chk("ld_ill_y", {29'd0, y}, 32'd0);
        chk("ld_ill_err", {31'd0, err}, 32'd1);
        step(1'b1, 1'b1, 3'b011, 1'b1, 1'b0);
        chk("ld_D_y", {29'd0, y}, 32'd3);
        chk("ld_D_err", {31'd0, err}, 32'd1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // 6. e_run saturation in E
        step(1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("sat_erun", {24'd0, e_run}, 32'd255);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
        chk("exitE_y", {29'd0, y}, 32'd3);
        chk("exitE_erun", {24'd0, e_run}, 32'd0);
        // mid-run reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        chk("midrst_y", {29'd0, y}, 32'd0);
        chk("midrst_erun", {24'd0, e_run}, 32'd0);
        chk("midrst_tc", {24'd0, trans_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
